// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared RAM.
interface ram_arbiter_if #(
    parameter int unsigned ADRS_W = 8,
    parameter int unsigned DATA_W = 8
) ();
    // Port 0 requester
    logic              req0;
    logic              we0;
    logic [ADRS_W-1:0] adrs0;
    logic [DATA_W-1:0] data0;
    logic              gnt0;
    logic              rvalid0;
    // Port 1 requester
    logic              req1;
    logic              we1;
    logic [ADRS_W-1:0] adrs1;
    logic [DATA_W-1:0] data1;
    logic              gnt1;
    logic              rvalid1;
    // Shared read return
    logic [DATA_W-1:0] rdata;
    // RAM side
    logic [ADRS_W-1:0] ram_adrs;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wr_en;
    logic [DATA_W-1:0] ram_q;

    // Arbiter view
    modport slave (
        input  req0, we0, adrs0, data0,
        input  req1, we1, adrs1, data1,
        input  ram_q,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
        output ram_adrs, ram_data, ram_wr_en
    );

    // Requesters plus RAM view
    modport master (
        output req0, we0, adrs0, data0,
        output req1, we1, adrs1, data1,
        output ram_q,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata,
        input  ram_adrs, ram_data, ram_wr_en
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between two requesters.
// A port keeps the RAM for at most MAX_BURST accesses while the other waits.
module ram_arbiter #(
    parameter int unsigned ADRS_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clock_in,
    input  logic          reset_N,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    localparam logic [3:0] BurstLast = 4'(MAX_BURST - 1);

    state_e            state_q, state_d;
    logic [3:0]        burst_q, burst_d;
    logic              last_q, last_d;  // last-served port
    logic              rvalid0_q, rvalid1_q;
    logic              acc0, acc1;
    logic [ADRS_W-1:0] sel_adrs;
    logic [DATA_W-1:0] sel_data;

    // Access qualification and RAM-side muxing
    always_comb begin
        acc0 = (state_q == StGnt0) && bus.req0;
        acc1 = (state_q == StGnt1) && bus.req1;
        // Outside an access the mux just follows the state; values are don't-care.
        if (state_q == StGnt1) begin
            sel_adrs = bus.adrs1;
            sel_data = bus.data1;
        end else begin
            sel_adrs = bus.adrs0;
            sel_data = bus.data0;
        end
    end

    // Next-state, burst counter and last-served pointer
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (bus.req0) begin
                    state_d = StGnt0;
                end else if (bus.req1) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!bus.req0) begin
                    state_d = bus.req1 ? StGnt1 : StIdle;
                end else if (bus.req1 && (burst_q == BurstLast)) begin
                    state_d = StGnt1;
                end
            end
            StGnt1: begin
                if (!bus.req1) begin
                    state_d = bus.req0 ? StGnt0 : StIdle;
                end else if (bus.req0 && (burst_q == BurstLast)) begin
                    state_d = StGnt0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            burst_d = '0;
            if (state_q == StGnt0) begin
                last_d = 1'b0;
            end else if (state_q == StGnt1) begin
                last_d = 1'b1;
            end
        end else if ((acc0 || acc1) && (burst_q != BurstLast)) begin
            // Saturates while the other port is idle; no forced switch then.
            burst_d = burst_q + 4'd1;
        end
    end

    // State registers; read-valid strobes follow a read access by one cycle
    always_ff @(posedge clock_in or negedge reset_N) begin
        if (!reset_N) begin
            state_q   <= StIdle;
            burst_q   <= '0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            last_q    <= last_d;
            rvalid0_q <= acc0 && !bus.we0;
            rvalid1_q <= acc1 && !bus.we1;
        end
    end

    // Output decode from registered state
    always_comb begin
        bus.gnt0      = (state_q == StGnt0);
        bus.gnt1      = (state_q == StGnt1);
        bus.rvalid0   = rvalid0_q;
        bus.rvalid1   = rvalid1_q;
        bus.rdata     = bus.ram_q;
        bus.ram_adrs  = sel_adrs;
        bus.ram_data  = sel_data;
        bus.ram_wr_en = (acc0 && bus.we0) || (acc1 && bus.we1);
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: RAM model, per-port requesters and a
// read-return scoreboard.
module tb_ram_arbiter;

    localparam int unsigned AW       = 8;
    localparam int unsigned DW       = 8;
    localparam int unsigned MaxBurst = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    ram_arbiter_if #(.ADRS_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter #(.ADRS_W(AW), .DATA_W(DW), .MAX_BURST(MaxBurst)) dut (
        .clock_in (clk),
        .reset_N  (rst_n),
        .bus      (bus)
    );

    typedef struct {int unsigned due; logic [7:0] data;} exp_t;
    typedef struct {bit we; logic [7:0] a; logic [7:0] d;} op_t;

    exp_t        q0[$];
    exp_t        q1[$];
    op_t         ops0[$];
    op_t         ops1[$];
    int          acc_port[$];
    int unsigned acc_cyc[$];
    int unsigned cyc    = 0;
    int unsigned wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];

    // Synchronous RAM model
    always @(posedge clk) begin
        if (bus.ram_wr_en) mem[bus.ram_adrs] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_adrs];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: grant exclusivity and read-return scoreboard
    always @(negedge clk) begin
        bit e0, e1;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (bus.ram_wr_en === 1'b1) wr_cnt++;
            checks++;
            if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1)
                begin errors++; $display("FAIL gnt_excl: gnt0=1 gnt1=1, want not both"); end
            checks++;
            if (bus.rvalid0 === 1'b1 && bus.rvalid1 === 1'b1)
                begin errors++; $display("FAIL rvalid_excl: both rvalid high, want not both"); end
            e0 = (q0.size() > 0) && (q0[0].due == cyc);
            e1 = (q1.size() > 0) && (q1[0].due == cyc);
            checks++;
            if (bus.rvalid0 !== e0)
                begin errors++; $display("FAIL rvalid0 cyc %0d: got %b want %b", cyc, bus.rvalid0, e0); end
            checks++;
            if (bus.rvalid1 !== e1)
                begin errors++; $display("FAIL rvalid1 cyc %0d: got %b want %b", cyc, bus.rvalid1, e1); end
            if (e0) begin
                checks++;
                if (bus.rdata !== q0[0].data) begin
                    errors++;
                    $display("FAIL rdata0 cyc %0d: got %h want %h", cyc, bus.rdata, q0[0].data);
                end
                void'(q0.pop_front());
            end
            if (e1) begin
                checks++;
                if (bus.rdata !== q1[0].data) begin
                    errors++;
                    $display("FAIL rdata1 cyc %0d: got %h want %h", cyc, bus.rdata, q1[0].data);
                end
                void'(q1.pop_front());
            end
        end
    end

    task automatic drive(input int p, input bit r, input op_t op);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = op.we; bus.adrs0 = op.a; bus.data0 = op.d;
        end else begin
            bus.req1 = r; bus.we1 = op.we; bus.adrs1 = op.a; bus.data1 = op.d;
        end
    endtask

    // Requester: holds req, consumes one op per granted cycle, then drops req
    task automatic run_port(input int p);
        op_t  op;
        int   t;
        logic g;
        exp_t e;
        while ((p == 0) ? (ops0.size() > 0) : (ops1.size() > 0)) begin
            if (p == 0) op = ops0.pop_front();
            else        op = ops1.pop_front();
            drive(p, 1'b1, op);
            t = 0;
            g = 1'b0;
            while (!g && t < 100) begin
                @(negedge clk);
                g = (p == 0) ? bus.gnt0 : bus.gnt1;
                t++;
            end
            if (g !== 1'b1) begin
                errors++;
                $display("FAIL grant_timeout port %0d: got no grant, want grant in 100 cycles", p);
                break;
            end
            checks++;
            if (bus.ram_wr_en !== op.we)
                begin errors++; $display("FAIL wr_en p%0d: got %b want %b", p, bus.ram_wr_en, op.we); end
            checks++;
            if (bus.ram_adrs !== op.a)
                begin errors++; $display("FAIL adrs p%0d: got %h want %h", p, bus.ram_adrs, op.a); end
            if (op.we) begin
                checks++;
                if (bus.ram_data !== op.d)
                    begin errors++; $display("FAIL data p%0d: got %h want %h", p, bus.ram_data, op.d); end
                ref_mem[op.a] = op.d;
            end else begin
                e.due  = cyc + 1;
                e.data = ref_mem[op.a];
                if (p == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            acc_port.push_back(p);
            acc_cyc.push_back(cyc);
            @(posedge clk);
            #1;
        end
        op.we = 1'b0;
        drive(p, 1'b0, op);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        acc_port.delete();
        acc_cyc.delete();
    endtask

    task automatic test_reset();
        op_t op;
        int  t;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0)
            begin errors++; $display("FAIL rst_gnt: got %b%b want 00", bus.gnt0, bus.gnt1); end
        checks++;
        if (bus.ram_wr_en !== 1'b0)
            begin errors++; $display("FAIL rst_wr_en: got %b want 0", bus.ram_wr_en); end
        checks++;
        if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0)
            begin errors++; $display("FAIL rst_rvalid: got %b%b want 00", bus.rvalid0, bus.rvalid1); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Reset in the middle of a read: rvalid in flight must vanish at once
        op.we = 1'b0; op.a = 8'h00; op.d = 8'h00;
        drive(0, 1'b1, op);
        t = 0;
        do begin @(negedge clk); t++; end while (bus.gnt0 !== 1'b1 && t < 20);
        checks++;
        if (bus.gnt0 !== 1'b1)
            begin errors++; $display("FAIL midrst_gnt: got %b want 1", bus.gnt0); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.rvalid0 !== 1'b1)
            begin errors++; $display("FAIL midrst_inflight: got rvalid0=%b want 1", bus.rvalid0); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rvalid0 !== 1'b0 || bus.gnt0 !== 1'b0 || bus.ram_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: got rvalid0=%b gnt0=%b wr_en=%b want 0 0 0",
                     bus.rvalid0, bus.gnt0, bus.ram_wr_en);
        end
        drive(0, 1'b0, op);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_writer();
        logic [7:0] wd [4];
        op_t op;
        wd[0] = 8'h11; wd[1] = 8'hAA; wd[2] = 8'hFF; wd[3] = 8'h55;
        clear_log();
        wr_cnt = 0;
        op.we = 1'b1; op.a = 8'h00; op.d = wd[0];
        drive(0, 1'b1, op);
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b0 || bus.ram_wr_en !== 1'b0)
            begin errors++; $display("FAIL gnt_latency: got gnt0=%b wr_en=%b want 0 0", bus.gnt0, bus.ram_wr_en); end
        for (int i = 0; i < 4; i++) begin
            op.we = 1'b1; op.a = 8'(i); op.d = wd[i];
            ops0.push_back(op);
        end
        op.we = 1'b0; op.a = 8'h01; op.d = 8'h00;
        ops0.push_back(op);
        run_port(0);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_cnt != 4)
            begin errors++; $display("FAIL single_wr_cnt: got %0d want 4", wr_cnt); end
        checks++;
        if (acc_cyc.size() != 5 || acc_cyc[acc_cyc.size()-1] - acc_cyc[0] != 4)
            begin errors++; $display("FAIL single_consec: got %0d accesses, want 5 consecutive", acc_cyc.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fair();
        op_t op;
        apply_reset();
        clear_log();
        for (int i = 0; i < 12; i++) begin
            op.we = 1'b1; op.a = 8'h10 + 8'(i); op.d = 8'h30 + 8'(i);
            ops0.push_back(op);
            op.we = 1'b1; op.a = 8'h20 + 8'(i); op.d = 8'h60 + 8'(i);
            ops1.push_back(op);
        end
        fork
            run_port(0);
            run_port(1);
        join
        checks++;
        if (acc_port.size() != 24) begin
            errors++;
            $display("FAIL fair_count: got %0d accesses want 24", acc_port.size());
        end else begin
            for (int i = 0; i < 24; i++) begin
                checks++;
                if (acc_port[i] != int'((i / MaxBurst) % 2)) begin
                    errors++;
                    $display("FAIL fair_order[%0d]: got port %0d want port %0d", i, acc_port[i],
                             (i / MaxBurst) % 2);
                end
            end
            checks++;
            if (acc_cyc[23] - acc_cyc[0] != 23)
                begin errors++; $display("FAIL fair_gap: got span %0d want 23", acc_cyc[23] - acc_cyc[0]); end
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_burst();
        op_t op;
        clear_log();
        for (int i = 0; i < 10; i++) begin
            op.we = 1'b0; op.a = 8'h10 + 8'(i); op.d = 8'h00;
            ops1.push_back(op);
        end
        run_port(1);
        checks++;
        if (acc_cyc.size() != 10 || acc_cyc[acc_cyc.size()-1] - acc_cyc[0] != 9)
            begin errors++; $display("FAIL burst_consec: got %0d accesses, want 10 consecutive", acc_cyc.size()); end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_switch();
        op_t op;
        logic [7:0] ra [4];
        ra[0] = 8'h00; ra[1] = 8'h01; ra[2] = 8'h00; ra[3] = 8'h02;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            op.we = 1'b0; op.a = ra[i]; op.d = 8'h00;
            ops0.push_back(op);
        end
        op.we = 1'b0; op.a = 8'h03; op.d = 8'h00;
        ops1.push_back(op);
        fork
            run_port(0);
            run_port(1);
        join
        checks++;
        if (acc_port.size() != 5 || acc_port[3] != 0 || acc_port[4] != 1) begin
            errors++;
            $display("FAIL switch_order: got %0d accesses, want port0 x4 then port1", acc_port.size());
        end else begin
            checks++;
            if (acc_cyc[4] != acc_cyc[3] + 1)
                begin errors++; $display("FAIL switch_gap: got %0d want %0d", acc_cyc[4], acc_cyc[3] + 1); end
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_drop();
        op_t op;
        clear_log();
        wr_cnt = 0;
        op.we = 1'b1; op.a = 8'h40; op.d = 8'h77;
        ops0.push_back(op);
        run_port(0);
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.ram_wr_en !== 1'b0)
            begin errors++; $display("FAIL drop_cycle: got gnt0=%b wr_en=%b want 1 0", bus.gnt0, bus.ram_wr_en); end
        @(negedge clk);
        checks++;
        if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0)
            begin errors++; $display("FAIL drop_idle: got gnt=%b%b want 00", bus.gnt0, bus.gnt1); end
        checks++;
        if (wr_cnt != 1)
            begin errors++; $display("FAIL drop_wr_cnt: got %0d want 1", wr_cnt); end
        @(posedge clk);
        #1;
        clear_log();
        op.we = 1'b1; op.a = 8'h41; op.d = 8'h78;
        ops0.push_back(op);
        op.we = 1'b1; op.a = 8'h42; op.d = 8'h79;
        ops1.push_back(op);
        fork
            run_port(0);
            run_port(1);
        join
        checks++;
        if (acc_port.size() != 2 || acc_port[0] != 1 || acc_port[1] != 0)
            begin errors++; $display("FAIL drop_tie: got %0d accesses, want port1 then port0", acc_port.size()); end
    endtask

    initial begin
        op_t idle;
        idle.we = 1'b0; idle.a = 8'h00; idle.d = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        drive(0, 1'b0, idle);
        drive(1, 1'b0, idle);
        test_reset();
        test_single_writer();
        test_fair();
        test_burst();
        test_read_switch();
        test_drop();
        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0)
            begin errors++; $display("FAIL pending_reads: got %0d/%0d left want 0/0", q0.size(), q1.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
